// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small byte FIFO: start bit, DATA_BITS data bits (LSB first),
// optional parity and STOP_BITS stop bits, with back-to-back frames while bytes are queued.
package uart_pkg;
  typedef enum int unsigned {
    BR_9600   = 9600,
    BR_19200  = 19200,
    BR_38400  = 38400,
    BR_57600  = 57600,
    BR_115200 = 115200,
    BR_230400 = 230400,
    BR_460800 = 460800,
    BR_921600 = 921600
  } uart_baud_rate_t;
endpackage

module uart_tx_fifo #(
  parameter int unsigned               CLK_FREQ_HZ = 100000000,
  parameter uart_pkg::uart_baud_rate_t BAUD_RATE   = uart_pkg::BR_115200,
  parameter int                        DATA_BITS   = 8,
  parameter int                        PARITY      = 0,
  parameter int                        STOP_BITS   = 1,
  parameter int                        FIFO_DEPTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [7:0]                    in_data,
  input  logic                          flush,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / 32'(BAUD_RATE);
  localparam int          AW           = $clog2(FIFO_DEPTH);
  localparam int          CW           = $clog2(STOP_BITS * CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_END    = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] STOP_END   = CW'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [2:0]  LAST_BIT     = 3'(DATA_BITS - 1);
  localparam logic [AW:0] DEPTH_L      = (AW + 1)'(FIFO_DEPTH);
  localparam logic [7:0]  DATA_MASK    = 8'((1 << DATA_BITS) - 1);
  localparam logic        ODD_PARITY   = (PARITY == 2);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("uart_tx_fifo: CLK_FREQ_HZ/BAUD_RATE must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("uart_tx_fifo: DATA_BITS must be 5..8");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t        state_q, state_n;
  logic [CW-1:0] baud_q, baud_n;
  logic [2:0]    bit_q, bit_n;
  logic          tx_q, tx_n;
  logic          line_active_q;
  logic [7:0]    shreg_q;
  logic          par_q;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;

  logic push, pop, shift, fifo_avail, bit_end, stop_end;

  function automatic logic frame_parity(input logic [7:0] d);
    return (^(d & DATA_MASK)) ^ ODD_PARITY;
  endfunction

  assign in_ready   = (count_q < DEPTH_L);
  assign push       = in_valid && in_ready && !flush;
  // A flush in the same cycle must not let the head escape into the shifter.
  assign fifo_avail = (count_q != '0) && !flush;
  assign bit_end    = (baud_q == BIT_END);
  assign stop_end   = (baud_q == STOP_END);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= wr_ptr_q;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + (AW + 1)'(1);
      else if (pop && !push) count_q <= count_q - (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      shreg_q <= mem[rd_ptr_q] & DATA_MASK;
      par_q   <= frame_parity(mem[rd_ptr_q]);
    end else if (shift) begin
      shreg_q <= {1'b0, shreg_q[7:1]};
    end
  end

  // tx follows the state by one register stage; line_active_q covers that lag for busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      baud_q        <= '0;
      bit_q         <= '0;
      tx_q          <= 1'b1;
      line_active_q <= 1'b0;
    end else begin
      state_q       <= state_n;
      baud_q        <= baud_n;
      bit_q         <= bit_n;
      tx_q          <= tx_n;
      line_active_q <= (state_q != S_IDLE);
    end
  end

  always_comb begin
    state_n = state_q;
    baud_n  = baud_q;
    bit_n   = bit_q;
    pop     = 1'b0;
    shift   = 1'b0;
    tx_n    = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (fifo_avail) begin
          pop     = 1'b1;
          baud_n  = '0;
          state_n = S_START;
        end
      end
      S_START: begin
        tx_n = 1'b0;
        if (bit_end) begin
          baud_n  = '0;
          bit_n   = '0;
          state_n = S_DATA;
        end else begin
          baud_n = baud_q + CW'(1);
        end
      end
      S_DATA: begin
        tx_n = shreg_q[0];
        if (bit_end) begin
          baud_n = '0;
          shift  = 1'b1;
          if (bit_q == LAST_BIT) state_n = (PARITY != 0) ? S_PARITY : S_STOP;
          else                   bit_n   = bit_q + 3'd1;
        end else begin
          baud_n = baud_q + CW'(1);
        end
      end
      S_PARITY: begin
        tx_n = par_q;
        if (bit_end) begin
          baud_n  = '0;
          state_n = S_STOP;
        end else begin
          baud_n = baud_q + CW'(1);
        end
      end
      S_STOP: begin
        if (stop_end) begin
          baud_n = '0;
          if (fifo_avail) begin
            pop     = 1'b1;
            state_n = S_START;
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          baud_n = baud_q + CW'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign tx         = tx_q;
  assign busy       = (state_q != S_IDLE) || (count_q != '0) || line_active_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three instances (8N1 depth 8, 7E2, 8N1 depth 4), all at 10 clocks per bit.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       in_valid_v [3];
  logic [7:0] in_data_v  [3];
  logic       flush_v    [3];
  logic       tx_a, tx_b, tx_c, busy_a, busy_b, busy_c, rdy_a, rdy_b, rdy_c;
  logic [3:0] count_a, count_b;
  logic [2:0] count_c;

  uart_tx_fifo #(.CLK_FREQ_HZ(1152000), .BAUD_RATE(BR_115200)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(rdy_a), .in_data(in_data_v[0]),
    .flush(flush_v[0]), .tx(tx_a), .busy(busy_a), .fifo_count(count_a));

  uart_tx_fifo #(.CLK_FREQ_HZ(1152000), .BAUD_RATE(BR_115200), .DATA_BITS(7), .PARITY(1),
                 .STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(rdy_b), .in_data(in_data_v[1]),
    .flush(flush_v[1]), .tx(tx_b), .busy(busy_b), .fifo_count(count_b));

  uart_tx_fifo #(.CLK_FREQ_HZ(1152000), .BAUD_RATE(BR_115200), .FIFO_DEPTH(4)) dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(rdy_c), .in_data(in_data_v[2]),
    .flush(flush_v[2]), .tx(tx_c), .busy(busy_c), .fifo_count(count_c));

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          sel;
    logic [7:0]  data;
    int          nbits;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs [7];
  logic [15:0] exp_c [6];

  function automatic logic tx_of(input int s);
    case (s)
      0: return tx_a;
      1: return tx_b;
      default: return tx_c;
    endcase
  endfunction

  function automatic logic busy_of(input int s);
    case (s)
      0: return busy_a;
      1: return busy_b;
      default: return busy_c;
    endcase
  endfunction

  function automatic logic ready_of(input int s);
    case (s)
      0: return rdy_a;
      1: return rdy_b;
      default: return rdy_c;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tmo(input string name);
    checks++;
    failures++;
    $display("FAIL %s timed out", name);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push(input int s, input logic [7:0] d, output int pcyc);
    int n;
    n = 0;
    in_valid_v[s] = 1'b1;
    in_data_v[s]  = d;
    while (!ready_of(s) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) tmo("push_ready");
    @(posedge clk);
    @(negedge clk);
    pcyc = cyc;
    in_valid_v[s] = 1'b0;
  endtask

  // Finds the start bit, then samples every bit in its middle; bits[0] is the start bit.
  task automatic get_frame(input int s, input int nbits, output logic [15:0] bits, output int t0);
    int n;
    n = 0;
    bits = '0;
    t0 = -1;
    while (tx_of(s) !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      tmo("frame_start");
      return;
    end
    t0 = cyc;
    for (int b = 0; b < nbits; b++) begin
      repeat ((b == 0) ? 5 : 10) @(negedge clk);
      bits[b] = tx_of(s);
    end
  endtask

  task automatic run_vec(input int s, input logic [7:0] d, input int nbits,
                         input logic [15:0] exp, input string name, output int pc);
    int t0;
    logic [15:0] got;
    push(s, d, pc);
    get_frame(s, nbits, got, t0);
    chk({name, "_frame"}, 32'(got), 32'(exp));
    chk({name, "_latency"}, t0 - pc, 2);
    repeat (4) @(negedge clk);
    chk({name, "_busy_tail"}, 32'(busy_of(s)), 1);
    @(negedge clk);
    chk({name, "_busy_end"}, 32'(busy_of(s)), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int pc, t0, rel, lows;
    logic [15:0] got;

    for (int s = 0; s < 3; s++) begin
      in_valid_v[s] = 1'b0;
      in_data_v[s]  = 8'h00;
      flush_v[s]    = 1'b0;
    end

    vecs[0] = '{0, 8'h55, 10, 16'b000000_1_01010101_0};
    vecs[1] = '{0, 8'h00, 10, 16'b000000_1_00000000_0};
    vecs[2] = '{0, 8'hFF, 10, 16'b000000_1_11111111_0};
    vecs[3] = '{0, 8'hA3, 10, 16'b000000_1_10100011_0};
    vecs[4] = '{1, 8'hD5, 11, 16'b00000_11_0_1010101_0};
    vecs[5] = '{1, 8'h07, 11, 16'b00000_11_1_0000111_0};
    vecs[6] = '{1, 8'h80, 11, 16'b00000_11_0_0000000_0};

    exp_c[0] = 16'b000000_1_00000001_0;
    exp_c[1] = 16'b000000_1_00000010_0;
    exp_c[2] = 16'b000000_1_00000011_0;
    exp_c[3] = 16'b000000_1_00000100_0;
    exp_c[4] = 16'b000000_1_00000101_0;
    exp_c[5] = 16'b000000_1_00000110_0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx_a), 1);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_count", 32'(count_a), 0);
    chk("rst_ready", 32'(rdy_a), 1);
    chk("rst_ready_c", 32'(rdy_c), 1);

    rel = cyc;
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i].sel, vecs[i].data, vecs[i].nbits, vecs[i].exp, $sformatf("vec%0d", i), pc);
      if (i == 0) chk("first_push_edge", pc - rel, 1);
    end

    // depth-4 FIFO with in_valid held high for six bytes
    fork
      begin : producer
        int n;
        in_valid_v[2] = 1'b1;
        for (int i = 1; i <= 6; i++) begin
          n = 0;
          in_data_v[2] = 8'(i);
          while (!rdy_c && n < 3000) begin
            @(negedge clk);
            n++;
          end
          if (n >= 3000) tmo("c_push_ready");
          @(posedge clk);
          @(negedge clk);
          if (i == 5) begin
            chk("c_full_count", 32'(count_c), 4);
            chk("c_full_ready", 32'(rdy_c), 0);
          end
        end
        in_valid_v[2] = 1'b0;
      end
      begin : consumer
        int prev, tc;
        logic [15:0] g;
        prev = 0;
        for (int k = 0; k < 6; k++) begin
          get_frame(2, 10, g, tc);
          chk($sformatf("c_frame%0d", k), 32'(g), 32'(exp_c[k]));
          if (k > 0) chk($sformatf("c_gap%0d", k), tc - prev, 100);
          prev = tc;
        end
      end
    join
    repeat (6) @(negedge clk);
    chk("c_idle_busy", 32'(busy_c), 0);

    // flush during the first frame's data bits, together with a push
    push(0, 8'h11, pc);
    push(0, 8'h22, pc);
    push(0, 8'h33, pc);
    fork
      begin
        get_frame(0, 10, got, t0);
      end
      begin
        repeat (30) @(negedge clk);
        chk("flush_pre_count", 32'(count_a), 2);
        flush_v[0]    = 1'b1;
        in_valid_v[0] = 1'b1;
        in_data_v[0]  = 8'h44;
        @(negedge clk);
        flush_v[0]    = 1'b0;
        in_valid_v[0] = 1'b0;
        chk("flush_count", 32'(count_a), 0);
      end
    join
    chk("flush_frame", 32'(got), 32'(16'b000000_1_00010001_0));
    repeat (4) @(negedge clk);
    chk("flush_busy_tail", 32'(busy_a), 1);
    @(negedge clk);
    chk("flush_busy_end", 32'(busy_a), 0);
    lows = 0;
    repeat (300) begin
      @(negedge clk);
      if (tx_a == 1'b0) lows++;
    end
    chk("flush_no_more_frames", lows, 0);

    // asynchronous reset while a zero data bit is on the line
    push(0, 8'h00, pc);
    push(0, 8'h0F, pc);
    repeat (40) @(negedge clk);
    chk("arst_pre_tx", 32'(tx_a), 0);
    chk("arst_pre_count", 32'(count_a), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_tx", 32'(tx_a), 1);
    chk("arst_count", 32'(count_a), 0);
    chk("arst_ready", 32'(rdy_a), 1);
    chk("arst_busy", 32'(busy_a), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_vec(0, 8'hC6, 10, 16'b000000_1_11000110_0, "post_rst", pc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 100000000, core clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default BR_115200 (uart_baud_rate_t), line bit rate.
REQ-003 Parameter DATA_BITS, default 8, frame data bits; legal range 5..8.
REQ-004 Parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-005 Parameter STOP_BITS, default 1, stop bits; legal values 1 or 2.
REQ-006 Parameter FIFO_DEPTH, default 8, entries; power of two, >= 2.
REQ-007 clk  input  1  core clock; one clock domain, all logic on rising edge.
REQ-008 rst  input  1  asynchronous, active-high reset.
REQ-009 in_valid  input  1  producer has a byte on in_data (rv_if RX side).
REQ-010 in_ready  output  1  FIFO can accept a byte.
REQ-011 in_data  input  8  byte to send; bits above DATA_BITS-1 ignored.
REQ-012 flush  input  1  single-cycle pulse that discards queued, unsent bytes.
REQ-013 tx  output  1  serial line, idle high.
REQ-014 busy  output  1  frame in progress or FIFO non-empty.
REQ-015 fifo_count  output  $clog2(FIFO_DEPTH)+1  number of bytes currently queued.

Function
REQ-016 CLKS_PER_BIT SHALL equal CLK_FREQ_HZ/BAUD_RATE (integer division, rounded down); values below 2 and illegal parameter values SHALL stop elaboration.
REQ-017 A push SHALL occur on a rising edge with in_valid=1 and in_ready=1; in_ready SHALL be 1 whenever fifo_count < FIFO_DEPTH, with no combinational dependence on in_valid.
REQ-018 A push and a pop in the same cycle SHALL leave fifo_count unchanged; a full FIFO SHALL NOT accept a push even when a pop happens in that cycle.
REQ-019 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH; ordering SHALL be strictly first in, first out.
REQ-020 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-021 IDLE: tx=1; when fifo_count>0, pop the head entry into the shift register and enter START on the next edge.
REQ-022 START: tx=0 for CLKS_PER_BIT cycles, then enter DATA.
REQ-023 DATA: send DATA_BITS bits LSB first, each for CLKS_PER_BIT cycles; then enter PARITY if PARITY!=0, otherwise STOP.
REQ-024 PARITY: tx = XOR of the sent data bits for even parity, or its inverse for odd parity, held for CLKS_PER_BIT cycles.
REQ-025 STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles; then pop the next entry and enter START directly if fifo_count>0, otherwise enter IDLE.
REQ-026 Back-to-back frames SHALL have no idle gap beyond the stop bits.
REQ-027 Latency: a byte pushed at edge N into an empty FIFO with the FSM in IDLE SHALL drive tx low from edge N+2.
REQ-028 flush SHALL set fifo_count to 0 on the next edge and take priority over a push in the same cycle; a frame already in progress SHALL complete unchanged.
REQ-029 busy SHALL be 1 when the state is not IDLE or fifo_count != 0.
REQ-030 tx SHALL be driven from a register, with no combinational glitches.

Reset
REQ-031 Asserting rst SHALL immediately and asynchronously force: state IDLE, tx=1, busy=0, fifo_count=0, in_ready=1, pointers 0, baud and bit counters 0.
REQ-032 Reset in the middle of a frame SHALL abort the frame, with tx returning high in the same cycle rst asserts; FIFO contents are lost.
REQ-033 After rst deasserts, the first push SHALL be accepted on the first rising edge.

Verification
REQ-034 CLK_FREQ_HZ=1152000, BAUD_RATE=BR_115200 (10 clocks/bit), 8N1; push 0x55 -> tx low for 10 cycles from edge N+2, then data 1,0,1,0,1,0,1,0 at 10 cycles each, then high; busy falls 100 cycles after tx first goes low.
REQ-035 DATA_BITS=7, PARITY=1, STOP_BITS=2; push 0xD5 -> data 1,0,1,0,1,0,1, parity bit 0, stop high for 20 cycles; bit 7 of in_data is not sent.
REQ-036 FIFO_DEPTH=4; hold in_valid=1 with 6 bytes 0x01..0x06 -> first byte pops, next 4 accepted, in_ready=0 at fifo_count=4; all 6 bytes are sent in order with no inter-frame gap.
REQ-037 Queue 3 bytes, pulse flush during the first frame's DATA state together with in_valid=1 -> the first frame completes, the other two bytes and the concurrent push are dropped, busy=0 after the stop bit.
REQ-038 Assert rst asynchronously mid-DATA while tx=0 -> tx=1, fifo_count=0, in_ready=1 before the next clock edge; a fresh push afterward produces a full, correct frame.
